// File: rtl/program_loader.sv
// program_loader: accepts a program image as a byte stream over a valid/ready
// handshake, writes the data bytes sequentially into a 256x8 memory, checks a
// trailing 8-bit checksum, enforces a per-byte timeout, and holds the CPU core
// off until a load has completed successfully.
//
// Handshake: a byte moves on a rising edge where i_in_valid && o_in_ready.
// o_in_ready is a registered decode of the state (high in LOAD and CHECK) and
// never depends on i_in_valid; the sender must hold i_in_data stable while
// i_in_valid is high.
module program_loader #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_load_len,
  input  logic       i_in_valid,
  input  logic [7:0] i_in_data,
  output logic       o_in_ready,
  output logic       o_mem_we,
  output logic [7:0] o_mem_addr,
  output logic [7:0] o_mem_d,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic       o_cpu_hold,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Timer value on the last idle cycle a byte is still allowed to arrive.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_ptr;
  logic [8:0]  r_remaining;
  logic [7:0]  r_sum;
  logic [15:0] r_timer;
  logic        r_in_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_cpu_hold;
  logic        r_mem_we;
  logic [7:0]  r_mem_addr;
  logic [7:0]  r_mem_d;

  logic        w_xfer;
  logic        w_start_acc;
  logic        w_timeout;
  logic [7:0]  w_sum_next;
  logic        w_in_ready_n;
  logic        w_busy_n;
  logic        w_done_n;
  logic        w_err_n;
  logic        w_cpu_hold_n;

  assign w_xfer      = i_in_valid && r_in_ready;
  assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERR));
  assign w_timeout   = (r_timer == TIMEOUT_LAST);
  assign w_sum_next  = r_sum + i_in_data;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: start only counts in the resting states, timeout only
  // while a byte is awaited.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_start_acc) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        if (w_xfer) begin
          if (r_remaining == 9'd1) w_next_state = S_CHECK;
        end else if (w_timeout) begin
          w_next_state = S_ERR;
        end
      end
      S_CHECK: begin
        if (w_xfer) begin
          w_next_state = (w_sum_next == 8'd0) ? S_DONE : S_ERR;
        end else if (w_timeout) begin
          w_next_state = S_ERR;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, so the registered flags line up with it.
  always_comb begin
    w_in_ready_n = (w_next_state == S_LOAD) || (w_next_state == S_CHECK);
    w_busy_n     = w_in_ready_n;
    w_done_n     = (w_next_state == S_DONE);
    w_err_n      = (w_next_state == S_ERR);
    w_cpu_hold_n = (w_next_state != S_DONE);
  end

  // Registered status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      r_in_ready <= w_in_ready_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_err      <= w_err_n;
      r_cpu_hold <= w_cpu_hold_n;
    end
  end

  // Datapath: load counters on start, write and accumulate each data byte,
  // count idle cycles while waiting for the next byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr       <= BASE_ADDR;
      r_remaining <= 9'd0;
      r_sum       <= 8'd0;
      r_timer     <= 16'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_d     <= 8'd0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_start_acc) begin
        r_remaining <= (i_load_len == 8'd0) ? 9'd256 : {1'b0, i_load_len};
        r_ptr       <= BASE_ADDR;
        r_sum       <= 8'd0;
        r_timer     <= 16'd0;
      end else if ((r_state == S_LOAD) || (r_state == S_CHECK)) begin
        if (w_xfer) begin
          r_timer <= 16'd0;
          if (r_state == S_LOAD) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_ptr;
            r_mem_d     <= i_in_data;
            r_ptr       <= r_ptr + 8'd1;
            r_sum       <= w_sum_next;
            r_remaining <= r_remaining - 9'd1;
          end
        end else begin
          r_timer <= r_timer + 16'd1;
        end
      end
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_d    = r_mem_d;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_cpu_hold = r_cpu_hold;
  assign o_state    = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus randomized loads. Expected
// memory writes go into a queue as bytes are issued; a monitor pops and
// compares on every mem_we pulse. Load outcome comes from plain arithmetic on
// the image and checksum.
module tb_program_loader;

  localparam logic [7:0] BASE = 8'hF0;
  localparam int         TMO  = 10;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] load_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_d;
  logic       busy;
  logic       done;
  logic       err;
  logic       cpu_hold;
  logic [2:0] state;

  program_loader #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_load_len(load_len),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_d(mem_d),
    .o_busy(busy), .o_done(done), .o_err(err), .o_cpu_hold(cpu_hold),
    .o_state(state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [15:0] exp_q[$];
  logic [7:0]  mem[256];
  logic [7:0]  img[256];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_writes = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      n_writes++;
      mem[mem_addr] = mem_d;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_d);
      end else begin
        chk("mem_write", {16'd0, mem_addr, mem_d}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks: all begin and end just after a falling edge
  task automatic do_start(input logic [7:0] len);
    start    = 1'b1;
    load_len = len;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    for (int g = 0; g < gap; g++) begin
      chk("in_ready_gap", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL handshake_wait: got in_ready 0 for 20 cycles expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Full load of img[0..n-1] followed by cks; checks the outcome against the model
  task automatic run_load(input int n, input logic [7:0] cks, input int gap_lo,
                          input int gap_hi, input bit poke_start);
    int  sum;
    bit  ok;
    sum = 0;
    do_start(8'(n));
    for (int i = 0; i < n; i++) begin
      sum += int'(img[i]);
      exp_q.push_back({BASE + 8'(i), img[i]});
      send_byte(img[i], $urandom_range(gap_hi, gap_lo));
      if (poke_start && i == n / 2) do_start(8'($urandom));
    end
    send_byte(cks, $urandom_range(gap_hi, gap_lo));
    ok = (((sum + int'(cks)) % 256) == 0);
    chk("done", {31'd0, done}, {31'd0, ok});
    chk("err", {31'd0, err}, {31'd0, !ok});
    chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !ok});
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("writes_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_mem_we"},   {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {24'd0, mem_addr}, {24'd0, BASE});
    chk({tag, "_mem_d"},    {24'd0, mem_d}, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
    chk({tag, "_done"},     {31'd0, done}, 32'd0);
    chk({tag, "_err"},      {31'd0, err}, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
  endtask

  task automatic set_nominal_img();
    img[0] = 8'h6C; img[1] = 8'h10; img[2] = 8'h9C; img[3] = 8'h58;
  endtask

  initial begin
    int n;
    int w0;
    int len;
    int sum;
    logic [7:0] cks;

    rst = 1'b1; start = 1'b0; load_len = 8'd0; in_valid = 1'b0; in_data = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hXX;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Nominal 4-byte load
    set_nominal_img();
    w0 = n_writes;
    run_load(4, 8'h90, 0, 0, 1'b0);
    chk("nominal_write_count", n_writes - w0, 32'd4);
    chk("nominal_mem0", {24'd0, mem[BASE]}, 32'h6C);
    chk("nominal_mem3", {24'd0, mem[BASE + 8'd3]}, 32'h58);

    // Bad checksum: data still lands in memory
    for (int i = 0; i < 4; i++) mem[BASE + 8'(i)] = 8'h00;
    run_load(4, 8'h91, 0, 0, 1'b0);
    chk("badcks_mem1", {24'd0, mem[BASE + 8'd1]}, 32'h10);
    chk("badcks_mem2", {24'd0, mem[BASE + 8'd2]}, 32'h9C);

    // Gaps of 3 idle cycles between bytes
    w0 = n_writes;
    run_load(4, 8'h90, 3, 3, 1'b0);
    chk("gap_write_count", n_writes - w0, 32'd4);

    // Timeout after two bytes
    do_start(8'd4);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({BASE + 8'(i), img[i]});
      send_byte(img[i], 0);
    end
    n = 0;
    while (err !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    chk("timeout_drained", exp_q.size(), 32'd0);
    run_load(4, 8'h90, 0, 2, 1'b0);

    // Full 256-byte image wrapping through FF -> 00
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    w0 = n_writes;
    run_load(256, 8'h80, 0, 1, 1'b0);
    chk("wrap_write_count", n_writes - w0, 32'd256);
    chk("wrap_memF0", {24'd0, mem[8'hF0]}, 32'h00);
    chk("wrap_memFF", {24'd0, mem[8'hFF]}, 32'h0F);
    chk("wrap_mem00", {24'd0, mem[8'h00]}, 32'h10);
    chk("wrap_memEF", {24'd0, mem[8'hEF]}, 32'hFF);

    // Asynchronous reset after two of four bytes
    set_nominal_img();
    do_start(8'd4);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({BASE + 8'(i), img[i]});
      send_byte(img[i], 0);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_drained", exp_q.size(), 32'd0);
    img[0] = 8'hA5; img[1] = 8'h3C; img[2] = 8'h01; img[3] = 8'h7E;
    run_load(4, 8'(256 - ((8'hA5 + 8'h3C + 8'h01 + 8'h7E) % 256)), 0, 0, 1'b0);
    chk("restart_mem_base", {24'd0, mem[BASE]}, 32'hA5);

    // Randomized loads with stray start pulses mid-load
    for (int t = 0; t < 10; t++) begin
      len = $urandom_range(24, 1);
      sum = 0;
      for (int i = 0; i < len; i++) begin
        img[i] = 8'($urandom);
        sum += int'(img[i]);
      end
      if ($urandom_range(1, 0) == 1) cks = 8'((256 - (sum % 256)) % 256);
      else cks = 8'($urandom);
      run_load(len, cks, 0, 5, 1'b1);
    end

    repeat (3) @(negedge clk);
    chk("final_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for memory_256x8. Receives a program image as a byte stream over a valid/ready handshake and writes it sequentially into memory through the `we`/`addr`/`d_i` port.
- Validates the image with a trailing 8-bit checksum and a per-byte timeout.
- Holds the CPU core off (`cpu_hold`) until a load completes successfully.

Parameters:
- BASE_ADDR, 8'h00, first memory address written; later addresses increment mod 256.
- TIMEOUT, 1000, max cycles allowed between accepted bytes while loading. Legal range 1..65535.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load. Sampled only in IDLE, DONE or ERR.
- load_len  input  8  byte count, sampled when start is accepted. 8'h00 means 256.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  to memory `we`.
- mem_addr  output  8  to memory `addr`.
- mem_d  output  8  to memory `d_i`.
- busy  output  1  high in LOAD or CHECK.
- done  output  1  high in DONE (load succeeded).
- err  output  1  high in ERR.
- cpu_hold  output  1  high in every state except DONE.

Behaviour:
- Reset values (applied immediately on rst assertion, independent of clk):
  - state = IDLE.
  - in_ready = 0, mem_we = 0, mem_addr = BASE_ADDR, mem_d = 0.
  - busy = 0, done = 0, err = 0, cpu_hold = 1.
  - Internal registers: ptr = BASE_ADDR, remaining = 0, sum = 0, timer = 0.
- Handshake: a byte is transferred on a rising edge where in_valid && in_ready. in_ready is a registered state decode, high only in LOAD and CHECK, and does not depend on in_valid. in_data must be stable while in_valid is high.
- States:
  - IDLE: start=1 -> LOAD. At the same time: remaining = (load_len == 0 ? 256 : load_len), a 9-bit count; ptr = BASE_ADDR; sum = 0; timer = 0.
  - LOAD, on a transfer:
    - Register mem_we = 1, mem_addr = ptr, mem_d = in_data. The memory captures the byte on the next edge, so the write lands exactly 1 cycle after the handshake.
    - ptr = ptr + 1 (8-bit wrap, FF -> 00); sum = sum + in_data (mod 256); remaining = remaining - 1; timer = 0.
    - If remaining was 1 -> CHECK.
  - LOAD, with no transfer: mem_we = 0 and timer increments. If timer reaches TIMEOUT-1 without a transfer -> ERR.
  - CHECK: the next transferred byte is the checksum and is not written (mem_we = 0). If (sum + byte) mod 256 == 0 -> DONE, else -> ERR. The timeout rule is the same as in LOAD.
  - DONE: cpu_hold = 0, done = 1. start=1 -> LOAD, re-initialised as from IDLE, and cpu_hold returns to 1.
  - ERR: err = 1, cpu_hold = 1. start=1 -> LOAD, re-initialised as from IDLE.
- mem_we is high for exactly one cycle per data byte and is never high outside the cycle following a LOAD transfer.
- start is ignored in LOAD and CHECK. A start coincident with the final transfer is also ignored.
- Outputs busy, done, err and cpu_hold are registered decodes of the state, valid in the cycle after each transition.
- Address wrap: a 256-byte load from BASE_ADDR != 0 wraps through FF -> 00 and overwrites no byte twice.
- Reset mid-load: everything returns to its reset values immediately. Memory contents already written are left as they are. The next load restarts at BASE_ADDR.

Test Plan:
1. Nominal 4-byte load (BASE_ADDR=00): start with load_len=4, send 6C,10,9C,58, then checksum 90 (data sum 70, 70+90 = 00 mod 256).
   - Memory addresses 00..03 read back 6C,10,9C,58.
   - done=1, cpu_hold=0 one cycle after the checksum transfer; exactly 4 mem_we pulses.
2. Bad checksum: same stream but checksum 91.
   - err=1, done=0, cpu_hold stays 1; data bytes are still in memory.
3. Backpressure/gaps: the same 4-byte image with in_valid low for 3 cycles between each byte, TIMEOUT=10.
   - Same result as scenario 1; no duplicate writes; in_ready high throughout LOAD and CHECK.
4. Timeout: TIMEOUT=10, load_len=4, send 2 bytes, then hold in_valid low.
   - err=1 exactly 10 cycles after the last accepted byte.
   - A following start with a full correct image reaches done=1.
5. Full 256-byte wrap: BASE_ADDR=F0, load_len=00, data byte i = i (0..255), checksum 80 (data sum 80, 80+80 = 00 mod 256).
   - Address F0 holds 00, FF holds 0F, 00 holds 10, EF holds FF; done=1.
6. Reset mid-load: assert rst asynchronously (between clock edges) after 2 of 4 bytes.
   - All outputs return to their reset values at once, before the next edge; cpu_hold=1.
   - A restart writes from BASE_ADDR again.
